adrv9001_tx_framer: RTL and testbench

- Parametrised TX lane framer in the dclk_div domain.
- Converts a handshaked I/Q sample stream into per-lane 8-bit parallel words plus a strobe word, ready for one 8:1 output serdes lane each.
- Adds enable/guard/drain sequencing, tristate control, test-pattern modes and underflow counting, none of which the per-lane serdes has.
- Sits between the TX DMA/DDS datapath and the data and strobe serdes lanes.

---
 rtl/adrv9001_tx_pkg.sv | 23 ++
 rtl/adrv9001_tx_pattern_gen.sv | 70 +++++++
 rtl/adrv9001_tx_framer.sv | 146 ++++++++++++++
 tb/tb_adrv9001_tx_framer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adrv9001_tx_pkg.sv
// Shared types and constants for the ADRV9001 TX lane framer.
// Holds the FSM encoding, the pattern mode codes, the strobe words and the symbol-length helper.
package adrv9001_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    RUN   = 2'd2
  } state_e;

  localparam logic [1:0] MODE_STREAM = 2'd0;
  localparam logic [1:0] MODE_RAMP   = 2'd1;
  localparam logic [1:0] MODE_CONST  = 2'd2;

  localparam logic [7:0] STROBE_SHORT_WORD = 8'h80;
  localparam logic [7:0] STROBE_LONG_WORD  = 8'hFF;

  // Serdes words needed to carry one I/Q symbol.
  function automatic int words_per_symbol(input int dw, input int lanes);
    return (lanes == 2) ? dw / 8 : 2 * dw / 8;
  endfunction

endpackage

// File: rtl/adrv9001_tx_pattern_gen.sv
// Symbol source for the TX framer: picks stream, ramp or constant data on load cycles.
// Also owns the ramp generator and the saturating underflow counter.
module adrv9001_tx_pattern_gen
  import adrv9001_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  dclk_div,
  input  logic                  rstn,
  input  logic                  load,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] const_i,
  input  logic [DATA_WIDTH-1:0] const_q,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic [DATA_WIDTH-1:0] s_data_q,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] sel_i,
  output logic [DATA_WIDTH-1:0] sel_q,
  output logic [15:0]           underflow_cnt
);

  logic [DATA_WIDTH-1:0] ramp_q, ramp_d;
  logic [15:0]           underflow_q, underflow_d;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    ramp_d      = ramp_q;
    underflow_d = underflow_q;
    sel_i       = '0;
    sel_q       = '0;
    s_ready     = 1'b0;
    if (load) begin
      case (mode)
        MODE_STREAM: begin
          s_ready = 1'b1;
          if (s_valid) begin
            sel_i = s_data_i;
            sel_q = s_data_q;
          end else if (underflow_q != 16'hFFFF) begin
            underflow_d = underflow_q + 16'd1;
          end
        end
        MODE_RAMP: begin
          sel_i  = ramp_q;
          sel_q  = ramp_q;
          ramp_d = ramp_q + DATA_WIDTH'(1);
        end
        default: begin
          sel_i = const_i;
          sel_q = const_q;
        end
      endcase
    end
  end

  // NOTE: non-blocking assignments make every flop update from the same pre-edge values.
  always_ff @(posedge dclk_div or negedge rstn) begin
    if (!rstn) begin
      ramp_q      <= '0;
      underflow_q <= '0;
    end else begin
      ramp_q      <= ramp_d;
      underflow_q <= underflow_d;
    end
  end

  assign underflow_cnt = underflow_q;

endmodule

// File: rtl/adrv9001_tx_framer.sv
// TX lane framer: sequences IDLE/GUARD/RUN and slices I/Q symbols into per-lane 8-bit serdes words.
// Output words are registered from next-state values so a symbol loaded in cycle k shows at k+1.
module adrv9001_tx_framer
  import adrv9001_tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int LANES        = 2,
  parameter int STROBE_LONG  = 0,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                  dclk_div,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] const_i,
  input  logic [DATA_WIDTH-1:0] const_q,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic [DATA_WIDTH-1:0] s_data_q,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [LANES*8-1:0]    dout,
  output logic [7:0]            strobe,
  output logic                  dout_t,
  output logic                  active,
  output logic [15:0]           underflow_cnt
);

  localparam int NW     = words_per_symbol(DATA_WIDTH, LANES);
  localparam int WCNT_W = $clog2(NW);
  localparam int SYM_W  = 2 * DATA_WIDTH;
  localparam logic [WCNT_W-1:0] WCNT_LAST  = WCNT_W'(NW - 1);
  localparam logic [WCNT_W-1:0] WCNT_HALF  = WCNT_W'(NW / 2);
  localparam logic [7:0]        GUARD_LOAD = 8'(GUARD_CYCLES - 1);

  state_e                state_q, state_d;
  logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
  logic [7:0]            guard_q, guard_d;
  logic [SYM_W-1:0]      sym_q, sym_d;
  logic [SYM_W-1:0]      shifted;
  logic [LANES*8-1:0]    dout_q, dout_d;
  logic [7:0]            strobe_q, strobe_d;
  logic                  dout_t_q, dout_t_d;
  logic                  active_q, active_d;
  logic                  load;
  logic [DATA_WIDTH-1:0] sel_i, sel_q;

  adrv9001_tx_pattern_gen #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_pattern (
    .dclk_div      (dclk_div),
    .rstn          (rstn),
    .load          (load),
    .mode          (mode),
    .const_i       (const_i),
    .const_q       (const_q),
    .s_data_i      (s_data_i),
    .s_data_q      (s_data_q),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .sel_i         (sel_i),
    .sel_q         (sel_q),
    .underflow_cnt (underflow_cnt)
  );

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    guard_d = guard_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = GUARD;
          guard_d = GUARD_LOAD;
        end
      end
      GUARD: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (guard_q == 8'd0) begin
          load    = 1'b1;
          state_d = RUN;
          wcnt_d  = '0;
        end else begin
          guard_d = guard_q - 8'd1;
        end
      end
      RUN: begin
        // A symbol in flight always completes; enable only matters at its last word.
        if (wcnt_q == WCNT_LAST) begin
          wcnt_d = '0;
          if (enable) load = 1'b1;
          else        state_d = IDLE;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sym_d    = load ? {sel_i, sel_q} : sym_q;
    shifted  = sym_d << {wcnt_d, 3'b000};
    dout_d   = '0;
    strobe_d = 8'h00;
    if (state_d == RUN) begin
      // Lane k reads the top byte of its half (LANES=2) or of the whole {I,Q} (LANES=1).
      for (int k = 0; k < LANES; k++) begin
        dout_d[8*k +: 8] = shifted[SYM_W-1-DATA_WIDTH*k -: 8];
      end
      if (STROBE_LONG != 0) strobe_d = (wcnt_d < WCNT_HALF) ? STROBE_LONG_WORD : 8'h00;
      else                  strobe_d = (wcnt_d == '0) ? STROBE_SHORT_WORD : 8'h00;
    end
    dout_t_d = (state_d == IDLE);
    active_d = (state_d != IDLE);
  end

  always_ff @(posedge dclk_div or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      guard_q  <= '0;
      sym_q    <= '0;
      dout_q   <= '0;
      strobe_q <= 8'h00;
      dout_t_q <= 1'b1;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      guard_q  <= guard_d;
      sym_q    <= sym_d;
      dout_q   <= dout_d;
      strobe_q <= strobe_d;
      dout_t_q <= dout_t_d;
      active_q <= active_d;
    end
  end

  assign dout   = dout_q;
  assign strobe = strobe_q;
  assign dout_t = dout_t_q;
  assign active = active_q;

endmodule

// File: tb/tb_adrv9001_tx_framer.sv
// Bench for adrv9001_tx_framer: a 2-lane short-strobe instance and a 1-lane long-strobe instance.
// Expected per-cycle lane words are queued when stimulus is driven and checked on the falling edge.
module tb_adrv9001_tx_framer;
  import adrv9001_tx_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        en_a = 1'b0, en_b = 1'b0;
  logic [1:0]  mode_a = MODE_STREAM, mode_b = MODE_CONST;
  logic [15:0] const_i = '0, const_q = '0, s_data_i = '0, s_data_q = '0;
  logic        s_valid = 1'b0;

  logic        s_ready_a, dout_t_a, active_a, s_ready_b, dout_t_b, active_b;
  logic [15:0] dout_a, uf_a, uf_b;
  logic [7:0]  dout_b, strobe_a, strobe_b;

  int errors = 0;
  int checks = 0;

  typedef struct packed {logic dt; logic [15:0] d; logic [7:0] s;} exp_a_t;
  typedef struct packed {logic dt; logic [7:0] d; logic [7:0] s;} exp_b_t;
  exp_a_t q_a[$];
  exp_b_t q_b[$];
  logic [15:0] smp_i[3], smp_q[3];

  adrv9001_tx_framer #(.DATA_WIDTH(16), .LANES(2), .STROBE_LONG(0), .GUARD_CYCLES(4)) dut_a (
    .dclk_div(clk), .rstn(rstn), .enable(en_a), .mode(mode_a), .const_i(const_i), .const_q(const_q),
    .s_data_i(s_data_i), .s_data_q(s_data_q), .s_valid(s_valid), .s_ready(s_ready_a),
    .dout(dout_a), .strobe(strobe_a), .dout_t(dout_t_a), .active(active_a), .underflow_cnt(uf_a));

  adrv9001_tx_framer #(.DATA_WIDTH(16), .LANES(1), .STROBE_LONG(1), .GUARD_CYCLES(4)) dut_b (
    .dclk_div(clk), .rstn(rstn), .enable(en_b), .mode(mode_b), .const_i(const_i), .const_q(const_q),
    .s_data_i(s_data_i), .s_data_q(s_data_q), .s_valid(s_valid), .s_ready(s_ready_b),
    .dout(dout_b), .strobe(strobe_b), .dout_t(dout_t_b), .active(active_b), .underflow_cnt(uf_b));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_a_t ea;
    exp_b_t eb;
    if (q_a.size() != 0) begin
      ea = q_a.pop_front();
      checks++;
      if ({dout_t_a, dout_a, strobe_a} !== ea || active_a !== ~ea.dt) begin
        errors++;
        $display("FAIL lane_a: got dt=%b dout=%h strobe=%h active=%b, expected dt=%b dout=%h strobe=%h",
                 dout_t_a, dout_a, strobe_a, active_a, ea.dt, ea.d, ea.s);
      end
    end
    if (q_b.size() != 0) begin
      eb = q_b.pop_front();
      checks++;
      if ({dout_t_b, dout_b, strobe_b} !== eb || active_b !== ~eb.dt) begin
        errors++;
        $display("FAIL lane_b: got dt=%b dout=%h strobe=%h active=%b, expected dt=%b dout=%h strobe=%h",
                 dout_t_b, dout_b, strobe_b, active_b, eb.dt, eb.d, eb.s);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_a(input logic dt, input logic [15:0] d, input logic [7:0] s, input int n);
    repeat (n) q_a.push_back({dt, d, s});
  endtask

  task automatic push_a_sym(input logic [15:0] i, input logic [15:0] q);
    push_a(1'b0, {q[15:8], i[15:8]}, 8'h80, 1);
    push_a(1'b0, {q[7:0], i[7:0]}, 8'h00, 1);
  endtask

  task automatic push_b(input logic dt, input logic [7:0] d, input logic [7:0] s, input int n);
    repeat (n) q_b.push_back({dt, d, s});
  endtask

  task automatic push_b_sym(input logic [15:0] i, input logic [15:0] q);
    push_b(1'b0, i[15:8], 8'hFF, 1);
    push_b(1'b0, i[7:0], 8'hFF, 1);
    push_b(1'b0, q[15:8], 8'h00, 1);
    push_b(1'b0, q[7:0], 8'h00, 1);
  endtask

  // Cycle c=0 raises enable; loads fall on c=4,6,8,... while enable is still high.
  task automatic drive_a(input int n, input int drop_c);
    int   idx;
    logic exp_rdy;
    for (int c = 0; c < n; c++) begin
      en_a = (c < drop_c);
      idx  = (c < 5) ? 0 : (c - 3) / 2;
      if (idx > 2) idx = 2;
      s_data_i = smp_i[idx];
      s_data_q = smp_q[idx];
      #1;
      exp_rdy = (mode_a == MODE_STREAM) && (c >= 4) && (c % 2 == 0) && (c < drop_c);
      checks++;
      if (s_ready_a !== exp_rdy) begin
        errors++;
        $display("FAIL s_ready_a c=%0d: got %b expected %b", c, s_ready_a, exp_rdy);
      end
      tick();
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 10 && (q_a.size() != 0 || q_b.size() != 0); k++) @(negedge clk);
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", q_a.size(), q_b.size());
    end
  endtask

  task automatic test_reset();
    #1 rstn = 1'b0;
    #1;
    checks++;
    if ({dout_t_a, dout_a, strobe_a, active_a, s_ready_a, uf_a} !== {1'b1, 16'h0, 8'h0, 1'b0, 1'b0, 16'h0} ||
        {dout_t_b, dout_b, strobe_b, active_b, s_ready_b, uf_b} !== {1'b1, 8'h0, 8'h0, 1'b0, 1'b0, 16'h0}) begin
      errors++;
      $display("FAIL reset_values: got a=%b/%h/%h b=%b/%h/%h expected 1/0000/00", dout_t_a, dout_a, strobe_a,
               dout_t_b, dout_b, strobe_b);
    end
    tick();
    tick();
    rstn = 1'b1;
    push_a(1'b1, 16'h0, 8'h0, 20);
    push_b(1'b1, 8'h0, 8'h0, 20);
    for (int c = 0; c < 20; c++) begin
      #1;
      checks++;
      if ({s_ready_a, s_ready_b, uf_a, uf_b} !== 34'h0) begin
        errors++;
        $display("FAIL idle_ctrl c=%0d: got rdy=%b%b uf=%h/%h expected 0 0", c, s_ready_a, s_ready_b, uf_a, uf_b);
      end
      tick();
    end
    wait_drain();
  endtask

  task automatic test_stream();
    tick();
    mode_a  = MODE_STREAM;
    s_valid = 1'b1;
    smp_i = '{16'hA55A, 16'h5AA5, 16'hFFFF};
    smp_q = '{16'h1234, 16'h8001, 16'h0000};
    push_a(1'b1, 16'h0, 8'h0, 1);
    push_a(1'b0, 16'h0, 8'h0, 4);
    for (int k = 0; k < 3; k++) push_a_sym(smp_i[k], smp_q[k]);
    push_a(1'b1, 16'h0, 8'h0, 2);
    drive_a(13, 9);
    wait_drain();
  endtask

  task automatic test_const_lanes1();
    tick();
    const_i = 16'hBEEF;
    const_q = 16'hCAFE;
    push_b(1'b1, 8'h0, 8'h0, 1);
    push_b(1'b0, 8'h0, 8'h0, 4);
    for (int k = 0; k < 3; k++) push_b_sym(16'hBEEF, 16'hCAFE);
    push_b(1'b1, 8'h0, 8'h0, 1);
    for (int c = 0; c < 18; c++) begin
      en_b   = (c < 14);
      mode_b = (c >= 7) ? 2'd3 : MODE_CONST;
      #1;
      checks++;
      if (s_ready_b !== 1'b0) begin
        errors++;
        $display("FAIL s_ready_b c=%0d: got %b expected 0", c, s_ready_b);
      end
      tick();
    end
    wait_drain();
  endtask

  task automatic test_underflow();
    tick();
    mode_a  = MODE_STREAM;
    s_valid = 1'b0;
    push_a(1'b1, 16'h0, 8'h0, 1);
    push_a(1'b0, 16'h0, 8'h0, 4);
    for (int k = 0; k < 3; k++) push_a_sym(16'h0, 16'h0);
    push_a(1'b1, 16'h0, 8'h0, 2);
    drive_a(13, 9);
    wait_drain();
    checks++;
    if (uf_a !== 16'd3) begin
      errors++;
      $display("FAIL underflow_count: got %h expected 0003", uf_a);
    end
  endtask

  task automatic test_underflow_saturate();
    tick();
    force dut_a.u_pattern.underflow_q = 16'hFFFE;
    #1 release dut_a.u_pattern.underflow_q;
    #1;
    checks++;
    if (uf_a !== 16'hFFFE) begin
      errors++;
      $display("FAIL underflow_preload: got %h expected fffe", uf_a);
    end
    tick();
    push_a(1'b1, 16'h0, 8'h0, 1);
    push_a(1'b0, 16'h0, 8'h0, 4);
    for (int k = 0; k < 5; k++) push_a_sym(16'h0, 16'h0);
    push_a(1'b1, 16'h0, 8'h0, 2);
    drive_a(17, 13);
    wait_drain();
    checks++;
    if (uf_a !== 16'hFFFF) begin
      errors++;
      $display("FAIL underflow_saturate: got %h expected ffff", uf_a);
    end
  endtask

  task automatic test_ramp_wrap();
    tick();
    force dut_a.u_pattern.ramp_q = 16'hFFFF;
    #1 release dut_a.u_pattern.ramp_q;
    tick();
    mode_a = MODE_RAMP;
    push_a(1'b1, 16'h0, 8'h0, 1);
    push_a(1'b0, 16'h0, 8'h0, 4);
    push_a_sym(16'hFFFF, 16'hFFFF);
    push_a_sym(16'h0000, 16'h0000);
    push_a_sym(16'h0001, 16'h0001);
    push_a(1'b1, 16'h0, 8'h0, 2);
    drive_a(13, 9);
    wait_drain();
  endtask

  task automatic test_reset_mid_symbol();
    tick();
    mode_a  = MODE_STREAM;
    s_valid = 1'b1;
    smp_i = '{16'hA55A, 16'hA55A, 16'hA55A};
    smp_q = '{16'h1234, 16'h1234, 16'h1234};
    push_a(1'b1, 16'h0, 8'h0, 1);
    push_a(1'b0, 16'h0, 8'h0, 4);
    drive_a(5, 100);
    checks++;
    if ({dout_t_a, dout_a, strobe_a} !== {1'b0, 16'h12A5, 8'h80}) begin
      errors++;
      $display("FAIL pre_reset_word: got dt=%b dout=%h strobe=%h expected 0/12a5/80", dout_t_a, dout_a, strobe_a);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({dout_t_a, dout_a, strobe_a, active_a, s_ready_a} !== {1'b1, 16'h0, 8'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: got dt=%b dout=%h strobe=%h act=%b expected 1/0000/00/0", dout_t_a, dout_a,
               strobe_a, active_a);
    end
    en_a = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
    checks++;
    if ({dout_t_a, dout_a, uf_a} !== {1'b1, 16'h0, 16'h0}) begin
      errors++;
      $display("FAIL post_reset_idle: got dt=%b dout=%h uf=%h expected 1/0000/0000", dout_t_a, dout_a, uf_a);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_const_lanes1();
    test_underflow();
    test_underflow_saturate();
    test_ramp_wrap();
    test_reset_mid_symbol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
